sample_streamer: RTL and testbench
==================================

Name: sample_streamer

Overview:
- Consumer side of the sampler readout handshake.
- Arms a capture by requesting sampling, then pulls each stored sample by generating rising edges on the sampler's next line.
- Latches each sample on the rising edge of valid and forwards it byte-by-byte to the serial transmitter through a start/done handshake.
- Ends when the sampler returns to idle; reports the number of samples streamed.

Parameters:
- DATA_SIZE, 8, width of a sample and of the transmitter data bus.
- COUNT_SIZE, 11, width of the streamed-sample counter; must cover 1024.
- NEXT_PULSE, 2, cycles o_next is held high per request.
- TIMEOUT, 64, maximum cycles from o_next falling to valid rising or idle before an error is declared.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle request to arm a capture and stream it.
- o_sample  out  1  sampling request to the sampler.
- i_idle  in  1  sampler idle flag.
- o_next  out  1  next-sample request to the sampler.
- i_data  in  DATA_SIZE  sampler read data.
- i_valid  in  1  sampler data valid; a multi-cycle level.
- o_tx_data  out  DATA_SIZE  byte to transmit.
- o_tx_start  out  1  one-cycle transmit start.
- i_tx_done  in  1  one-cycle transmit-complete pulse.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when streaming completes.
- o_error  out  1  sticky timeout flag; cleared by reset or the next i_start.
- o_count  out  COUNT_SIZE  samples sent in the current or last run.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; internal last_valid and timer cleared.
- Edge detection: last_valid is registered every cycle. rise_valid = i_valid & ~last_valid. Only rise_valid latches data, so the sampler's 4-cycle valid yields exactly one sample.
- IDLE: on i_start, clear o_count and o_error, go to ARM.
- ARM: o_sample=1. When i_idle=0, set o_sample=0 and go to FIRST. o_sample is registered, so it deasserts the cycle after i_idle is seen low.
- FIRST: wait without limit for rise_valid, because capture depends on external gates.
  - On rise_valid: latch i_data into o_tx_data, go to SEND.
  - If i_idle rises first: go to FINISH with o_count=0.
- SEND: o_tx_start=1 for exactly one cycle, o_count+=1 (saturating at all-ones), go to WAIT_TX.
- WAIT_TX: hold o_tx_data stable, wait for i_tx_done, then go to NEXT.
  - i_tx_done outside WAIT_TX is ignored.
- NEXT: o_next=1 for NEXT_PULSE cycles, then o_next=0, timer=0, go to WAIT_VALID.
  - o_next is always low for at least 1 cycle before being raised again, so the sampler sees a clean edge.
- WAIT_VALID: checks in priority order, first match wins:
  1. i_idle=1 → FINISH. The sampler wraps to idle after its last address; this is the normal end.
  2. rise_valid → latch i_data, go to SEND.
  3. timer==TIMEOUT-1 → o_error=1, go to FINISH.
  4. Otherwise timer+=1.
- FINISH: o_done=1 for one cycle; o_next=0, o_sample=0; go to IDLE.
- i_start while o_busy=1 is ignored.
- Reset mid-run returns all outputs to 0 immediately, without waiting for a clock edge.
- Counter: o_count is held after FINISH until the next i_start.
- Latency:
  - rise_valid to o_tx_start: 1 cycle.
  - i_tx_done to o_next high: 1 cycle.

Decomposition:
- Shared package holds:
  - State encoding (3 bits): IDLE=0, ARM=1, FIRST=2, SEND=3, WAIT_TX=4, NEXT=5, WAIT_VALID=6, FINISH=7.
  - Sampler handshake constants: MEM_SIZE=1024, valid width 4.
- No sub-module is needed. An optional edge_detect helper may be shared with the sampler's gate/next edge logic.

Test Plan:
- Single sample: i_start; drop i_idle 3 cycles later; raise i_valid for 4 cycles with i_data=8'hA5 → o_sample high until the cycle after i_idle falls; exactly one o_tx_start; o_tx_data=8'hA5; o_count=1.
- Handshake ordering: delay i_tx_done 20 cycles → o_next stays low until 1 cycle after i_tx_done, then is high for exactly 2 cycles; o_tx_data stable throughout.
- Full run: sampler model delivers data 0..1022, then raises idle → 1023 o_tx_start pulses, bytes in order (mod 256), o_count=1023, one o_done, o_error=0.
- Timeout: after the first sample, never raise i_valid and keep i_idle=0 → o_error=1 at 64 cycles after o_next falls; o_done pulse; back to IDLE.
- Glitches: valid held 4 cycles, plus i_tx_done pulsed in WAIT_VALID, plus i_start pulsed while busy → no duplicate sends; state unaffected.
- Async reset asserted in WAIT_TX, mid-cycle → outputs 0 before the next clock edge; a new i_start works normally afterwards.

Source files
------------

// File: rtl/sample_streamer_pkg.sv
// Shared definitions for the sampler readout consumer: FSM state encoding,
// sampler handshake constants and the edge helper used on sampler levels.
package sample_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_FIRST      = 3'd2,
    ST_SEND       = 3'd3,
    ST_WAIT_TX    = 3'd4,
    ST_NEXT       = 3'd5,
    ST_WAIT_VALID = 3'd6,
    ST_FINISH     = 3'd7
  } state_t;

  localparam int MEM_SIZE    = 32'd1024;
  localparam int VALID_WIDTH = 32'd4;

  function automatic logic rising_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sample_streamer.sv
// Consumer side of the sampler readout: arms a capture, pulls samples one by
// one with pulses on o_next and forwards each byte to the serial transmitter.
module sample_streamer
  import sample_streamer_pkg::*;
#(
  parameter int DATA_SIZE  = 8,
  parameter int COUNT_SIZE = 11,
  parameter int NEXT_PULSE = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_sample,
  input  logic                  i_idle,
  output logic                  o_next,
  input  logic [DATA_SIZE-1:0]  i_data,
  input  logic                  i_valid,
  output logic [DATA_SIZE-1:0]  o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [COUNT_SIZE-1:0] o_count
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int PULSE_W = $clog2(NEXT_PULSE + 1);
  localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [PULSE_W-1:0]    PULSE_LAST = PULSE_W'(NEXT_PULSE - 1);
  localparam logic [COUNT_SIZE-1:0] COUNT_MAX  = {COUNT_SIZE{1'b1}};

  state_t                  state_q, state_d;
  logic                    last_valid_q;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [PULSE_W-1:0]      pulse_q, pulse_d;
  logic                    sample_q, sample_d;
  logic                    next_q, next_d;
  logic [DATA_SIZE-1:0]    tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [COUNT_SIZE-1:0]   count_q, count_d;
  logic                    rise_valid_s;

  assign rise_valid_s = rising_edge(i_valid, last_valid_q);

  // Next-state and next-output computation for the readout sequence.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pulse_d   = pulse_q;
    sample_d  = sample_q;
    next_d    = next_q;
    tx_data_d = tx_data_q;
    count_d   = count_q;
    error_d   = error_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          count_d  = {COUNT_SIZE{1'b0}};
          error_d  = 1'b0;
          sample_d = 1'b1;
          state_d  = ST_ARM;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (!i_idle) begin
          sample_d = 1'b0;
          state_d  = ST_FIRST;
        end else begin
          sample_d = 1'b1;
        end
      end
      // Capture depends on external gates, so the first sample has no deadline.
      ST_FIRST: begin
        if (i_idle) begin
          state_d = ST_FINISH;
        end else if (rise_valid_s) begin
          tx_data_d = i_data;
          state_d   = ST_SEND;
        end else begin
          state_d = ST_FIRST;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          next_d  = 1'b1;
          pulse_d = {PULSE_W{1'b0}};
          state_d = ST_NEXT;
        end else begin
          state_d = ST_WAIT_TX;
        end
      end
      ST_NEXT: begin
        if (pulse_q == PULSE_LAST) begin
          next_d  = 1'b0;
          timer_d = {TIMER_W{1'b0}};
          state_d = ST_WAIT_VALID;
        end else begin
          pulse_d = pulse_q + PULSE_W'(1);
        end
      end
      // Sampler returning to idle after its last address is the normal end.
      ST_WAIT_VALID: begin
        if (i_idle) begin
          state_d = ST_FINISH;
        end else if (rise_valid_s) begin
          tx_data_d = i_data;
          state_d   = ST_SEND;
        end else if (timer_q == TIMER_LAST) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_FINISH: begin
        next_d   = 1'b0;
        sample_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_SEND) begin
      count_d = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_SIZE'(1);
    end else begin
      count_d = count_d;
    end

    tx_start_d = (state_d == ST_SEND);
    done_d     = (state_d == ST_FINISH);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, edge history and registered outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      last_valid_q <= 1'b0;
      timer_q      <= {TIMER_W{1'b0}};
      pulse_q      <= {PULSE_W{1'b0}};
      sample_q     <= 1'b0;
      next_q       <= 1'b0;
      tx_data_q    <= {DATA_SIZE{1'b0}};
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      count_q      <= {COUNT_SIZE{1'b0}};
    end else begin
      state_q      <= state_d;
      last_valid_q <= i_valid;
      timer_q      <= timer_d;
      pulse_q      <= pulse_d;
      sample_q     <= sample_d;
      next_q       <= next_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      count_q      <= count_d;
    end
  end

  assign o_sample   = sample_q;
  assign o_next     = next_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Bench for sample_streamer: the bench plays sampler and transmitter, and a
// transaction-level model checks sends, handshakes and run results every cycle.
module tb_sample_streamer;
  import sample_streamer_pkg::*;

  localparam int NEXT_PULSE = 2;

  logic        i_clock, i_reset, i_start, o_sample, i_idle, o_next;
  logic [7:0]  i_data, o_tx_data;
  logic        i_valid, o_tx_start, i_tx_done, o_busy, o_done, o_error;
  logic [10:0] o_count;

  int          checks, errors;
  logic [7:0]  exp_q[$];
  int          exp_total;
  logic        exp_error;
  int          sends;
  int          tx_min, tx_max;
  logic        glitch_tog;

  sample_streamer dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .o_sample(o_sample),
    .i_idle(i_idle), .o_next(o_next), .i_data(i_data), .i_valid(i_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_count(o_count)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Transmitter: answers each start with one done pulse after a random delay.
  initial begin : transmitter
    int   cnt;
    logic seen;
    cnt = 0;
    seen = 1'b0;
    i_tx_done = 1'b0;
    forever begin
      tick();
      i_tx_done = 1'b0;
      if (i_reset) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) i_tx_done = 1'b1;
      end else if (glitch_tog != seen) begin
        seen = glitch_tog;
        i_tx_done = 1'b1;
      end
      if (o_tx_start) cnt = $urandom_range(tx_max, tx_min);
    end
  end

  // Compare process: checks DUT outputs against the transaction model each cycle.
  initial begin : monitor
    logic       v1, v2, done_p, nxt1, start1, done1, pend, outst;
    logic [7:0] cur, want;
    int         nrun;
    v1 = 1'b0; v2 = 1'b0; done_p = 1'b0; nxt1 = 1'b0; start1 = 1'b0;
    done1 = 1'b0; pend = 1'b0; outst = 1'b0; cur = 8'h00; nrun = 0;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        v1 = 1'b0; v2 = 1'b0; done_p = 1'b0; nxt1 = 1'b0; start1 = 1'b0;
        done1 = 1'b0; pend = 1'b0; outst = 1'b0; nrun = 0; sends = 0;
      end else begin
        if (pend) begin
          chk("start_clears_count", 32'(o_count), 32'd0);
          chk("start_clears_error", 32'(o_error), 32'd0);
          chk("start_sets_busy", 32'(o_busy), 32'd1);
          sends = 0;
        end
        pend = i_start & ~o_busy;
        if (outst) begin
          chk("tx_data_stable", 32'(o_tx_data), 32'(cur));
          chk("next_low_during_tx", 32'(o_next), 32'd0);
          if (i_tx_done) outst = 1'b0;
        end
        if (o_tx_start) begin
          chk("tx_start_one_cycle", 32'(start1), 32'd0);
          chk("valid_rise_to_start", 32'({v2, v1}), 32'd1);
          chk("send_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk("tx_byte", 32'(o_tx_data), 32'(want));
          end
          sends++;
          outst = 1'b1;
          cur = o_tx_data;
        end
        chk("count_tracks_sends", 32'(o_count), 32'(sends));
        if (o_next && !nxt1) chk("done_to_next", 32'(done_p), 32'd1);
        if (o_next) begin
          nrun++;
        end else if (nxt1) begin
          chk("next_width", 32'(nrun), 32'(NEXT_PULSE));
          nrun = 0;
        end
        if (o_done) begin
          chk("done_one_cycle", 32'(done1), 32'd0);
          chk("done_busy", 32'(o_busy), 32'd1);
          chk("done_count", 32'(o_count), 32'(exp_total));
          chk("done_error", 32'(o_error), 32'(exp_error));
          chk("done_next_low", 32'(o_next), 32'd0);
        end
        if (done1) chk("idle_after_done", 32'(o_busy), 32'd0);
        v2 = v1; v1 = i_valid; done_p = i_tx_done; nxt1 = o_next;
        start1 = o_tx_start; done1 = o_done;
      end
    end
  end

  task automatic wait_next();
    int cnt = 0;
    while (!o_next && cnt < 500) begin tick(); cnt++; end
    while (o_next && cnt < 500) begin tick(); cnt++; end
    chk("next_handshake_bound", 32'(cnt < 500), 32'd1);
  endtask

  // mode: 0 normal end, 1 silent sampler after first sample, 2 glitch injection.
  // dmode: 0 random bytes, 1 index bytes, 2 constant A5.
  task automatic do_run(input int n, input int mode, input int dmode, input int cap);
    int cnt;
    logic [7:0] d;
    exp_total = (mode == 1) ? 1 : n;
    exp_error = (mode == 1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("arm_sample_high", 32'(o_sample), 32'd1);
    chk("arm_busy", 32'(o_busy), 32'd1);
    tick();
    tick();
    chk("sample_held_while_idle", 32'(o_sample), 32'd1);
    i_idle = 1'b0;
    tick();
    chk("sample_drop", 32'(o_sample), 32'd0);
    repeat (cap) tick();
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        wait_next();
        if (mode == 2) begin
          glitch_tog = ~glitch_tog;
          repeat ($urandom_range(4, 2)) tick();
        end else begin
          repeat ($urandom_range(3, 0)) tick();
        end
      end
      d = (dmode == 0) ? 8'($urandom_range(255, 0)) : (dmode == 1) ? 8'(k) : 8'hA5;
      exp_q.push_back(d);
      i_data = d;
      i_valid = 1'b1;
      if (mode == 2) i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (VALID_WIDTH - 1) tick();
      i_valid = 1'b0;
      i_data = 8'($urandom_range(255, 0));
      if (mode == 1) break;
    end
    if (n > 0) wait_next();
    if (mode == 1) begin
      cnt = 0;
      while (!o_error && cnt < 200) begin tick(); cnt++; end
      chk("timeout_cycles", 32'(cnt), 32'd64);
    end else begin
      repeat ($urandom_range(3, 0)) tick();
      i_idle = 1'b1;
    end
    cnt = 0;
    while (!o_done && cnt < 200) begin tick(); cnt++; end
    chk("done_seen", 32'(o_done), 32'd1);
    tick();
    chk("back_to_idle", 32'(o_busy), 32'd0);
    chk("error_after_run", 32'(o_error), 32'(exp_error));
    chk("count_held", 32'(o_count), 32'(exp_total));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    i_idle = 1'b1;
    repeat (3) tick();
  endtask

  initial begin : main
    checks = 0; errors = 0; sends = 0; exp_total = 0; exp_error = 1'b0;
    tx_min = 1; tx_max = 3; glitch_tog = 1'b0;
    i_reset = 1'b1; i_start = 1'b0; i_idle = 1'b1; i_data = 8'h00; i_valid = 1'b0;
    tick();
    chk("rst_sample", 32'(o_sample), 32'd0);
    chk("rst_next", 32'(o_next), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_tx_start", 32'(o_tx_start), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    tick();
    i_reset = 1'b0;
    repeat (2) tick();

    // Single sample with a known byte.
    do_run(1, 0, 2, 3);
    chk("single_tx_data", 32'(o_tx_data), 32'hA5);
    chk("single_count", 32'(o_count), 32'd1);

    // Slow transmitter, then several random runs.
    tx_min = 20; tx_max = 20;
    do_run(3, 0, 0, 2);
    tx_min = 1; tx_max = 6;
    for (int r = 0; r < 4; r++) do_run($urandom_range(20, 2), 0, 0, $urandom_range(10, 0));

    // No sample before the sampler goes idle again; long first wait does not time out.
    do_run(0, 0, 0, 5);
    do_run(2, 0, 0, 100);

    // Glitches: start while busy, stray tx_done while waiting for valid.
    do_run(6, 2, 0, 4);

    // Silent sampler after the first sample, then a clean run clears the error.
    do_run(1, 1, 0, 2);
    chk("error_sticky_idle", 32'(o_error), 32'd1);
    do_run(4, 0, 0, 1);

    // Asynchronous reset while waiting for the transmitter.
    tx_min = 30; tx_max = 30;
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick(); i_idle = 1'b0; tick();
    i_data = 8'h3C; exp_q.push_back(8'h3C); i_valid = 1'b1;
    repeat (VALID_WIDTH) tick();
    i_valid = 1'b0;
    tick();
    chk("pre_reset_busy", 32'(o_busy), 32'd1);
    chk("pre_reset_count", 32'(o_count), 32'd1);
    #2 i_reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    chk("async_rst_count", 32'(o_count), 32'd0);
    chk("async_rst_tx_data", 32'(o_tx_data), 32'd0);
    chk("async_rst_sample", 32'(o_sample), 32'd0);
    chk("async_rst_next", 32'(o_next), 32'd0);
    tick(); tick();
    i_reset = 1'b0; i_idle = 1'b1;
    exp_q.delete();
    repeat (3) tick();
    tx_min = 1; tx_max = 4;
    do_run(5, 0, 0, 3);

    // Full memory readout.
    tx_min = 1; tx_max = 2;
    do_run(MEM_SIZE - 1, 0, 1, 2);
    chk("full_count", 32'(o_count), 32'd1023);
    chk("full_last_byte", 32'(o_tx_data), 32'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
